// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: data/pause/UART stalls and masked IRQ arbitration.
// Define HAZARD_STATS_EN to add the saturating stall_cycles counter output.
module pipeline_hazard_controller #(
    parameter int unsigned     STAGE_CNT  = 5,
    parameter int unsigned     REG_ADDR_W = 5,
    parameter int unsigned     PC_W       = 32,
    parameter logic [PC_W-1:0] PC_MAX     = PC_W'(32'h3FFF),
    parameter int unsigned     IRQ_CNT    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reg_1_valid,
    input  logic                    reg_2_valid,
    input  logic [REG_ADDR_W-1:0]   id_reg_1_idx,
    input  logic [REG_ADDR_W-1:0]   id_reg_2_idx,
    input  logic                    branch_instruction,
    input  logic                    ex_mem_read_enable,
    input  logic                    ex_reg_write_enable,
    input  logic                    ex_no_op,
    input  logic [REG_ADDR_W-1:0]   ex_reg_dest_idx,
    input  logic                    mem_reg_write_enable,
    input  logic                    mem_no_op,
    input  logic [REG_ADDR_W-1:0]   mem_reg_dest_idx,
    input  logic [PC_W-1:0]         pc_next,
    input  logic                    cpu_pause,
    input  logic                    uart_complete,
    input  logic [IRQ_CNT-1:0]      irq_req,
    input  logic [IRQ_CNT-1:0]      irq_mask,
    input  logic [IRQ_CNT-1:0]      irq_done,
    output logic [IRQ_CNT-1:0]      irq_grant,
    output logic                    uart_disable,
    output logic                    pc_reset,
    output logic [2*STAGE_CNT-1:0]  hazard_control,
    output logic [2:0]              issue_type
`ifdef HAZARD_STATS_EN
   ,output logic [31:0]             stall_cycles
`endif
);

    localparam int unsigned HC_W = 2 * STAGE_CNT;

    localparam logic [1:0] HC_NORMAL = 2'b00;
    localparam logic [1:0] HC_HOLD   = 2'b01;
    localparam logic [1:0] HC_NO_OP  = 2'b10;

    localparam logic [2:0] ISSUE_NONE  = 3'd0;
    localparam logic [2:0] ISSUE_DATA  = 3'd1;
    localparam logic [2:0] ISSUE_PAUSE = 3'd2;
    localparam logic [2:0] ISSUE_UART  = 3'd3;
    localparam logic [2:0] ISSUE_IRQ   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_EXECUTE   = 2'd1,
        S_HAZARD    = 2'd2,
        S_INTERRUPT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [HC_W-1:0]    hazard_control_q, hazard_control_d;
    logic [2:0]         issue_type_q, issue_type_d;
    logic [IRQ_CNT-1:0] irq_grant_q, irq_grant_d;
    logic               pc_reset_q, pc_reset_d;
    logic               uart_disable_q, uart_disable_d;

    logic               ex_conflict;
    logic               mem_conflict;
    logic               data_hazard;
    logic               uart_hazard;
    logic [IRQ_CNT-1:0] irq_masked;
    logic               irq_pending;
    logic [IRQ_CNT-1:0] irq_lowest;
    logic               serial_resolved;
    logic               irq_exit;

    // Hazard detection on the current ID/EX/MEM snapshot
    always_comb begin
        ex_conflict  = ex_reg_write_enable && !ex_no_op &&
                       ((reg_1_valid && (id_reg_1_idx == ex_reg_dest_idx)) ||
                        (reg_2_valid && (id_reg_2_idx == ex_reg_dest_idx)));
        mem_conflict = mem_reg_write_enable && !mem_no_op &&
                       ((reg_1_valid && (id_reg_1_idx == mem_reg_dest_idx)) ||
                        (reg_2_valid && (id_reg_2_idx == mem_reg_dest_idx)));
        data_hazard  = (branch_instruction && (ex_conflict || mem_conflict)) ||
                       (ex_mem_read_enable && ex_conflict);
        uart_hazard  = pc_next > PC_MAX;
        irq_masked   = irq_req & irq_mask;
        irq_pending  = |irq_masked;
        // two's-complement trick isolates the lowest set bit
        irq_lowest   = irq_masked & (~irq_masked + IRQ_CNT'(1));
        serial_resolved = uart_complete &&
                          ((issue_type_q != ISSUE_PAUSE) || !cpu_pause);
        irq_exit     = |(irq_done & irq_grant_q);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            hazard_control_q <= '0;
            issue_type_q     <= ISSUE_NONE;
            irq_grant_q      <= '0;
            pc_reset_q       <= 1'b0;
            uart_disable_q   <= 1'b1;
        end else begin
            state_q          <= state_d;
            hazard_control_q <= hazard_control_d;
            issue_type_q     <= issue_type_d;
            irq_grant_q      <= irq_grant_d;
            pc_reset_q       <= pc_reset_d;
            uart_disable_q   <= uart_disable_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (data_hazard || cpu_pause || uart_hazard) begin
                    state_d = S_HAZARD;
                end else if (irq_pending) begin
                    state_d = S_INTERRUPT;
                end
            end
            S_HAZARD: begin
                if (issue_type_q == ISSUE_DATA) begin
                    if (!data_hazard) begin
                        state_d = S_EXECUTE;
                    end
                end else if (serial_resolved) begin
                    state_d = S_EXECUTE;
                end
            end
            S_INTERRUPT: begin
                if (irq_exit) begin
                    state_d = S_EXECUTE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; pc_reset defaults low so it only pulses for one cycle
    always_comb begin
        hazard_control_d = hazard_control_q;
        issue_type_d     = issue_type_q;
        irq_grant_d      = irq_grant_q;
        pc_reset_d       = 1'b0;
        uart_disable_d   = uart_disable_q;
        case (state_q)
            S_EXECUTE: begin
                if (data_hazard) begin
                    hazard_control_d[1:0] = HC_HOLD;
                    hazard_control_d[3:2] = HC_HOLD;
                    hazard_control_d[5:4] = HC_NO_OP;
                    issue_type_d          = ISSUE_DATA;
                end else if (cpu_pause || uart_hazard) begin
                    hazard_control_d[1:0] = HC_NO_OP;
                    uart_disable_d        = 1'b0;
                    issue_type_d          = cpu_pause ? ISSUE_PAUSE : ISSUE_UART;
                end else if (irq_pending) begin
                    hazard_control_d = {STAGE_CNT{HC_NO_OP}};
                    irq_grant_d      = irq_lowest;
                    issue_type_d     = ISSUE_IRQ;
                end
            end
            S_HAZARD: begin
                if (issue_type_q == ISSUE_DATA) begin
                    if (!data_hazard) begin
                        hazard_control_d[5:0] = {3{HC_NORMAL}};
                        issue_type_d          = ISSUE_NONE;
                    end
                end else if (serial_resolved) begin
                    hazard_control_d[1:0] = HC_NORMAL;
                    uart_disable_d        = 1'b1;
                    pc_reset_d            = 1'b1;
                    issue_type_d          = ISSUE_NONE;
                end else if (cpu_pause) begin
                    issue_type_d = ISSUE_PAUSE;
                end
            end
            S_INTERRUPT: begin
                if (irq_exit) begin
                    hazard_control_d = {STAGE_CNT{HC_NORMAL}};
                    irq_grant_d      = '0;
                    issue_type_d     = ISSUE_NONE;
                end
            end
            default: ;
        endcase
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of cycles spent stalled or servicing an interrupt
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (((state_q == S_HAZARD) || (state_q == S_INTERRUPT)) &&
            (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

    assign hazard_control = hazard_control_q;
    assign issue_type     = issue_type_q;
    assign irq_grant      = irq_grant_q;
    assign pc_reset       = pc_reset_q;
    assign uart_disable   = uart_disable_q;

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter STAGE_CNT, default 5: number of pipeline stage registers controlled, minimum 3.
REQ-002 SHALL have parameter REG_ADDR_W, default 5: register index width.
REQ-003 SHALL have parameter PC_W, default 32: pc_next width.
REQ-004 SHALL have parameter PC_MAX, default 'h3FFF: highest valid instruction address.
REQ-005 SHALL have parameter IRQ_CNT, default 4: number of interrupt request lines, 1..8.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with ports clk (in, 1) and rst (in, 1).
REQ-007 SHALL have inputs reg_1_valid and reg_2_valid (1 each): ID source register valid.
REQ-008 SHALL have inputs id_reg_1_idx and id_reg_2_idx (REG_ADDR_W each): ID source register indices.
REQ-009 SHALL have input branch_instruction (1): ID holds a branch.
REQ-010 SHALL have inputs ex_mem_read_enable, ex_reg_write_enable and ex_no_op (1 each), plus ex_reg_dest_idx (REG_ADDR_W): EX stage status.
REQ-011 SHALL have inputs mem_reg_write_enable and mem_no_op (1 each), plus mem_reg_dest_idx (REG_ADDR_W): MEM stage status.
REQ-012 SHALL have input pc_next (PC_W).
REQ-013 SHALL have inputs cpu_pause and uart_complete (1 each).
REQ-014 SHALL have inputs irq_req, irq_mask and irq_done (IRQ_CNT each): request, enable and completion per line.
REQ-015 SHALL have output irq_grant (IRQ_CNT): one-hot served line.
REQ-016 SHALL have outputs uart_disable (1) and pc_reset (1).
REQ-017 SHALL have output hazard_control (2*STAGE_CNT): stage k uses bits [2k+1:2k]; stage 0 = IF, 1 = ID, 2 = EX.
REQ-018 SHALL have output issue_type (3).
REQ-019 SHALL have output stall_cycles (32), present only under the Configuration macro.

Function
REQ-020 SHALL update all state and outputs on posedge clk only; every output is registered, so a response appears one edge after its condition is sampled.
REQ-021 SHALL encode hazard control as NORMAL = 2'b00, HOLD = 2'b01, NO_OP = 2'b10; 2'b11 is never driven.
REQ-022 SHALL encode issue_type as NONE = 0, DATA = 1, PAUSE = 2, UART = 3, IRQ = 4.
REQ-023 SHALL implement states IDLE, EXECUTE, HAZARD and INTERRUPT; IDLE goes to EXECUTE unconditionally on the next edge.
REQ-024 SHALL assert ex_conflict when ex_reg_write_enable is high, ex_no_op is low, and a valid ID source index equals ex_reg_dest_idx; mem_conflict is defined likewise with the MEM signals.
REQ-025 SHALL compute data_hazard = (branch_instruction & (ex_conflict | mem_conflict)) | (ex_mem_read_enable & ex_conflict).
REQ-026 SHALL compute uart_hazard = pc_next > PC_MAX (unsigned).
REQ-027 SHALL compute irq_pending = |(irq_req & irq_mask).
REQ-028 SHALL, in EXECUTE, resolve simultaneous events with priority data_hazard > cpu_pause > uart_hazard > irq_pending.
REQ-029 SHALL, in EXECUTE on data_hazard, set stages 0-1 to HOLD and stage 2 to NO_OP, set issue DATA, and enter HAZARD.
REQ-030 SHALL, in EXECUTE on cpu_pause, drive uart_disable low, set stage 0 to NO_OP, set issue PAUSE, and enter HAZARD.
REQ-031 SHALL, in EXECUTE on uart_hazard, act as on cpu_pause but with issue UART.
REQ-032 SHALL, in EXECUTE on irq_pending, set all stages to NO_OP, set irq_grant to the lowest-index masked-in request, set issue IRQ, and enter INTERRUPT.
REQ-033 SHALL, in HAZARD/DATA, restore stages 0-2 to NORMAL and go to EXECUTE with issue NONE on the first edge where data_hazard is low.
REQ-034 SHALL, in HAZARD with UART or PAUSE, resolve when uart_complete is high and (for PAUSE) cpu_pause is low; on resolution it raises uart_disable, sets stage 0 to NORMAL, pulses pc_reset high for exactly one cycle, and sets issue NONE.
REQ-035 SHALL, in HAZARD/UART, change issue to PAUSE if cpu_pause is high and resolution is not met.
REQ-036 SHALL, in INTERRUPT, hold irq_grant stable while ignoring irq_req changes, and exit only when irq_done is high on the granted bit.
REQ-037 SHALL, on INTERRUPT exit, set all stages to NORMAL, clear irq_grant, set issue NONE, and enter EXECUTE; a still-pending request is re-granted no earlier than the following edge.
REQ-038 SHALL ignore irq_done on non-granted bits.
REQ-039 SHALL treat irq_mask changes during INTERRUPT as having no effect on the current grant.

Reset
REQ-040 SHALL, when rst is high at a posedge, set the state to IDLE, hazard_control to all NORMAL, issue_type to NONE, irq_grant to 0, pc_reset to 0, uart_disable to 1 and stall_cycles to 0, overriding any in-progress hazard or interrupt.

Configuration
REQ-041 SHALL, when HAZARD_STATS_EN is defined, provide stall_cycles: incremented by 1 each cycle the state is HAZARD or INTERRUPT, saturating at 32'hFFFFFFFF, and cleared only by rst.
REQ-042 SHALL, when HAZARD_STATS_EN is undefined, omit the stall_cycles port and its counter logic.

Verification
REQ-043 SHALL cover a load-use hazard: ex_mem_read_enable = 1, ex_reg_dest_idx = 5, id_reg_1_idx = 5, reg_1_valid = 1 -> next edge gives stage0 = 01, stage1 = 01, stage2 = 10, issue 1; dropping the hazard -> next edge gives all 00, issue 0.
REQ-044 SHALL cover simultaneous events: data_hazard, cpu_pause and irq_req = 4'b0110 (mask 4'b1111) in one cycle -> issue DATA, irq_grant = 0.
REQ-045 SHALL cover UART-to-PAUSE escalation: pc_next = PC_MAX+1 -> issue 3, uart_disable = 0; cpu_pause = 1 -> issue 2; then cpu_pause = 0 and uart_complete = 1 -> pc_reset high for exactly one cycle, uart_disable = 1.
REQ-046 SHALL cover interrupt arbitration: irq_req = 4'b1010, irq_mask = 4'b1000 -> irq_grant = 4'b1000, all stages 10; irq_done = 4'b0010 -> no change; irq_done = 4'b1000 -> all 00, grant 0.
REQ-047 SHALL cover reset mid-INTERRUPT: rst = 1 -> next edge gives all outputs at reset values; the first edge after rst goes low leaves IDLE -> EXECUTE.
REQ-048 SHALL cover stall counting with HAZARD_STATS_EN defined: a 7-cycle DATA stall -> stall_cycles = 7.
